// File: rtl/constraint_stream_checker.sv
// Two-stage elastic checker: evaluates a per-variable constraint on each candidate,
// AND-reduces over a mask and emits one verdict per candidate with saturating statistics.
module constraint_stream_checker #(
    parameter int NUM_VARS = 8,
    parameter int VAR_W    = 8,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_VARS*VAR_W-1:0] in_vars,
    input  logic [1:0]                in_mode,
    input  logic [VAR_W-1:0]          in_thresh,
    input  logic [NUM_VARS-1:0]       in_mask,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sat,
    output logic [CNT_W-1:0]          sat_cnt,
    output logic [CNT_W-1:0]          unsat_cnt,
    input  logic                      clear
);

    logic                s1_valid_r;
    logic [NUM_VARS-1:0] s1_res_r;
    logic [NUM_VARS-1:0] res_s;
    logic                out_valid_r;
    logic                out_sat_r;
    logic [CNT_W-1:0]    sat_cnt_r;
    logic [CNT_W-1:0]    unsat_cnt_r;
    logic                s2_load_s;
    logic                accept_s;
    logic                handshake_s;

    function automatic logic eval_var(
        input logic [VAR_W-1:0] v,
        input logic [1:0]       mode,
        input logic [VAR_W-1:0] thresh
    );
        logic ok;
        case (mode)
            2'd0:    ok = (v != {VAR_W{1'b0}});
            2'd1:    ok = (v == {VAR_W{1'b0}});
            2'd2:    ok = (v >= thresh);
            2'd3:    ok = 1'b1;
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] n;
        if (c == {CNT_W{1'b1}}) begin
            n = c;
        end else begin
            n = c + CNT_W'(1);
        end
        return n;
    endfunction

    assign s2_load_s   = ~out_valid_r | out_ready;
    assign in_ready    = ~s1_valid_r | s2_load_s;
    assign accept_s    = in_valid & in_ready;
    assign handshake_s = out_valid_r & out_ready;

    // Per-variable results; unmasked variables are forced true.
    always_comb begin
        res_s = {NUM_VARS{1'b0}};
        for (int i = 0; i < NUM_VARS; i++) begin
            res_s[i] = eval_var(in_vars[i*VAR_W +: VAR_W], in_mode, in_thresh) | ~in_mask[i];
        end
    end

    // Stage 1: capture per-variable results on acceptance, empty when S2 takes the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_res_r   <= {NUM_VARS{1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_res_r   <= res_s;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: verdict register, held stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_sat_r   <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            out_sat_r   <= s1_valid_r & (&s1_res_r);
        end
    end

    // Statistics: clear takes priority over a coinciding handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt_r   <= {CNT_W{1'b0}};
            unsat_cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            sat_cnt_r   <= {CNT_W{1'b0}};
            unsat_cnt_r <= {CNT_W{1'b0}};
        end else if (handshake_s) begin
            if (out_sat_r) begin
                sat_cnt_r <= sat_inc(sat_cnt_r);
            end else begin
                unsat_cnt_r <= sat_inc(unsat_cnt_r);
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_sat   = out_sat_r;
    assign sat_cnt   = sat_cnt_r;
    assign unsat_cnt = unsat_cnt_r;

endmodule
